// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, owner codes and counter-width helper
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;
    // Bits needed to hold the values 0..v-1, never less than one
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_arb_prio_streak.sv
// arb_prio_streak: data-priority arbitration with a streak guard that forces a fetch grant
module arb_prio_streak
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid_i,
    input  logic dm_valid_i,
    input  logic grant_en_i,
    output logic grant_if_o,
    output logic grant_dm_o
);
    localparam int SW = clog2(MAX_DM_STREAK + 1);
    logic [SW-1:0] streak_q;
    logic both, force_if;
    always_comb begin
        both       = if_valid_i & dm_valid_i;
        force_if   = both && streak_q == SW'(MAX_DM_STREAK);
        grant_dm_o = dm_valid_i & ~force_if;
        grant_if_o = if_valid_i & ~grant_dm_o;
    end
    // Only contested data wins lengthen the streak; any fetch grant ends it
    always_ff @(posedge clk) begin
        if (rst)
            streak_q <= '0;
        else if (grant_en_i)
            streak_q <= grant_if_o ? '0 : both ? streak_q + SW'(1) : streak_q;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters,
// one outstanding transaction at a time, with a response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_valid,
    input  logic [WIDTH-1:0] if_req_addr,
    output logic             if_req_ready,
    output logic             if_rsp_valid,
    output logic [WIDTH-1:0] if_rsp_data,
    input  logic             dm_req_valid,
    input  logic             dm_req_we,
    input  logic [WIDTH-1:0] dm_req_addr,
    input  logic [WIDTH-1:0] dm_req_wdata,
    input  logic [3:0]       dm_req_be,
    output logic             dm_req_ready,
    output logic             dm_rsp_valid,
    output logic [WIDTH-1:0] dm_rsp_rdata,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_be,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_rdata,
    output logic             busy,
    output logic             owner,
    output logic             err
);
    localparam int TW = clog2(TIMEOUT + 1);
    state_e state_q, state_d;
    logic owner_q, we_q, if_rsp_q, dm_rsp_q;
    logic [WIDTH-1:0] addr_q, wdata_q, if_data_q, dm_data_q;
    logic [3:0] be_q;
    logic [TW-1:0] cnt_q;
    logic grant_if, grant_dm, hold, accept, rsp_hit, rsp_if, rsp_dm, expire, exp_if, exp_dm;

    arb_prio_streak #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .if_valid_i (if_req_valid),
        .dm_valid_i (dm_req_valid),
        .grant_en_i (accept),
        .grant_if_o (grant_if),
        .grant_dm_o (grant_dm)
    );

    always_comb begin
        // A grant to the other requester waits one cycle while a response pulse is out
        hold          = (if_rsp_q & grant_dm) | (dm_rsp_q & grant_if);
        accept        = !rst && state_q == IDLE && (grant_if || grant_dm) && !hold;
        rsp_hit       = state_q == WAIT && mem_rsp_valid;
        rsp_if        = rsp_hit && owner_q == OWNER_IF;
        rsp_dm        = rsp_hit && owner_q == OWNER_DM;
        expire        = TIMEOUT != 0 && !rst && state_q != IDLE && cnt_q == TW'(TIMEOUT) && !rsp_hit;
        exp_if        = expire && owner_q == OWNER_IF;
        exp_dm        = expire && owner_q == OWNER_DM;
        state_d       = expire ? IDLE
                      : state_q == IDLE  ? (accept ? ISSUE : IDLE)
                      : state_q == ISSUE ? (mem_req_ready ? WAIT : ISSUE)
                      : rsp_hit ? IDLE : WAIT;
        if_req_ready  = accept & grant_if;
        dm_req_ready  = accept & grant_dm;
        mem_req_valid = state_q == ISSUE && !expire;
        mem_req_we    = we_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_be    = be_q;
        if_rsp_valid  = if_rsp_q | exp_if;
        dm_rsp_valid  = dm_rsp_q | exp_dm;
        if_rsp_data   = exp_if ? '0 : if_data_q;
        dm_rsp_rdata  = exp_dm ? '0 : dm_data_q;
        busy          = state_q != IDLE;
        owner         = owner_q;
        err           = expire;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWNER_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
            if_rsp_q  <= 1'b0;
            dm_rsp_q  <= 1'b0;
            if_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            cnt_q    <= state_q == IDLE ? '0 : cnt_q + TW'(1);
            if_rsp_q <= rsp_if;
            dm_rsp_q <= rsp_dm;
            if (accept) begin
                owner_q <= grant_dm ? OWNER_DM : OWNER_IF;
                we_q    <= grant_dm & dm_req_we;
                addr_q  <= grant_dm ? dm_req_addr : if_req_addr;
                wdata_q <= grant_dm ? dm_req_wdata : '0;
                be_q    <= grant_dm ? dm_req_be : 4'hF;
            end
            if (rsp_if || exp_if)
                if_data_q <= rsp_hit ? mem_rsp_rdata : '0;
            if (rsp_dm || exp_dm)
                dm_data_q <= rsp_hit ? mem_rsp_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req_valid = 0, dm_req_valid = 0, dm_req_we = 0;
    logic [31:0] if_req_addr = 0, dm_req_addr = 0, dm_req_wdata = 0, mem_rsp_rdata = 0;
    logic [3:0]  dm_req_be = 0;
    logic        mem_req_ready = 1, mem_rsp_valid = 0;
    logic        if_req_ready, if_rsp_valid, dm_req_ready, dm_rsp_valid;
    logic        mem_req_valid, mem_req_we, busy, owner, err;
    logic [31:0] if_rsp_data, dm_rsp_rdata, mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;

    int total = 0, bad = 0;
    bit auto_mem = 0;

    mem_port_arbiter #(.WIDTH(32), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    // Reference model: phase 0 idle, 1 request on the bus, 2 awaiting response
    int          m_phase, m_age, m_streak, m_rsp_who;
    bit          m_ok = 0, m_owner, m_we;
    logic [31:0] m_addr, m_wdata, m_ifd, m_dmd;
    logic [3:0]  m_be;

    always @(negedge clk) begin
        int win;
        bit acc, ex, both;
        if (rst) begin
            m_ok = 1; m_phase = 0; m_age = 0; m_streak = 0; m_rsp_who = -1;
            m_owner = 0; m_ifd = 0; m_dmd = 0;
        end else if (m_ok) begin
            both = if_req_valid && dm_req_valid;
            ex   = m_phase != 0 && m_age == TO && !(m_phase == 2 && mem_rsp_valid);
            win  = both ? (m_streak == MAXS ? 0 : 1) : if_req_valid ? 0 : dm_req_valid ? 1 : -1;
            acc  = m_phase == 0 && win >= 0 && !(m_rsp_who >= 0 && m_rsp_who != win);
            chk("if_req_ready", if_req_ready, acc && win == 0);
            chk("dm_req_ready", dm_req_ready, acc && win == 1);
            chk("mem_req_valid", mem_req_valid, m_phase == 1 && !ex);
            if (m_phase == 1 && !ex) begin
                chk("mem_req_addr", mem_req_addr, m_addr);
                chk("mem_req_we", mem_req_we, m_we);
                if (m_owner) begin
                    chk("mem_req_wdata", mem_req_wdata, m_wdata);
                    chk("mem_req_be", mem_req_be, m_be);
                end
            end
            chk("if_rsp_valid", if_rsp_valid, m_rsp_who == 0 || (ex && !m_owner));
            chk("dm_rsp_valid", dm_rsp_valid, m_rsp_who == 1 || (ex && m_owner));
            chk("if_rsp_data", if_rsp_data, (ex && !m_owner) ? 32'h0 : m_ifd);
            chk("dm_rsp_rdata", dm_rsp_rdata, (ex && m_owner) ? 32'h0 : m_dmd);
            chk("busy", busy, m_phase != 0);
            chk("owner", owner, m_owner);
            chk("err", err, ex);
            m_rsp_who = (m_phase == 2 && mem_rsp_valid) ? int'(m_owner) : -1;
            if (m_phase == 2 && mem_rsp_valid) begin
                if (m_owner) m_dmd = mem_rsp_rdata; else m_ifd = mem_rsp_rdata;
                m_phase = 0;
            end else if (ex) begin
                if (m_owner) m_dmd = 0; else m_ifd = 0;
                m_phase = 0;
            end else if (m_phase == 1 && mem_req_ready) m_phase = 2;
            m_age++;
            if (acc) begin
                m_owner  = win == 1;
                m_addr   = m_owner ? dm_req_addr : if_req_addr;
                m_we     = m_owner && dm_req_we;
                m_wdata  = dm_req_wdata;
                m_be     = dm_req_be;
                m_streak = win == 0 ? 0 : both ? m_streak + 1 : m_streak;
                m_age    = 0;
                m_phase  = 1;
            end
        end
    end

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the sample point; optionally answers a handshake one cycle later
    task automatic adv();
        logic hs;
        logic [31:0] a;
        hs = mem_req_valid && mem_req_ready;
        a  = mem_req_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_rsp_valid = hs;
            mem_rsp_rdata = a ^ 32'h5A5A0000;
        end
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        int n, rsp_cnt;
        bit got;
        logic [9:0] seq;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_if_data", if_rsp_data, 0);
        adv();

        // Single fetch with zero-wait memory
        if_req_valid = 1; if_req_addr = 32'h100;
        settle(); chk("a_accept", if_req_ready, 1); adv();
        if_req_valid = 0;
        settle(); chk("a_mem_valid", mem_req_valid, 1); chk("a_mem_addr", mem_req_addr, 32'h100); adv();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h00500093;
        settle(); adv();
        mem_rsp_valid = 0;
        settle();
        chk("a_rsp_valid", if_rsp_valid, 1);
        chk("a_rsp_data", if_rsp_data, 32'h00500093);
        chk("a_busy", busy, 0);
        adv();

        // Continuous contention: streak guard
        auto_mem = 1; seq = 0; n = 0; rsp_cnt = 0;
        if_req_addr = 32'h40; dm_req_addr = 32'h80; dm_req_we = 0;
        if_req_valid = 1; dm_req_valid = 1;
        for (int c = 0; c < 100 && n < 10; c++) begin
            settle();
            rsp_cnt += int'(if_rsp_valid) + int'(dm_rsp_valid);
            if (if_req_ready) begin seq[n] = 1'b0; n++; end
            else if (dm_req_ready) begin seq[n] = 1'b1; n++; end
            adv();
        end
        if_req_valid = 0; dm_req_valid = 0;
        repeat (6) begin
            settle();
            rsp_cnt += int'(if_rsp_valid) + int'(dm_rsp_valid);
            adv();
        end
        auto_mem = 0;
        chk("b_grant_count", n, 10);
        chk("b_grant_seq", seq, 10'b0111101111);
        chk("b_rsp_count", rsp_cnt, 10);

        // Store held on a stalled bus
        dm_req_valid = 1; dm_req_we = 1; dm_req_addr = 32'h2000; dm_req_wdata = 32'hDEADBEEF; dm_req_be = 4'b0011;
        settle(); chk("c_accept", dm_req_ready, 1); adv();
        dm_req_valid = 0; dm_req_we = 0; dm_req_addr = 32'hBAD0; dm_req_wdata = 0; dm_req_be = 4'hC;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            settle();
            chk("c_valid", mem_req_valid, 1);
            chk("c_addr", mem_req_addr, 32'h2000);
            chk("c_wdata", mem_req_wdata, 32'hDEADBEEF);
            chk("c_be", mem_req_be, 4'b0011);
            chk("c_we", mem_req_we, 1);
            adv();
        end
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h11111111;
        settle(); adv();
        mem_rsp_valid = 0;
        settle(); chk("c_rsp", dm_rsp_valid, 1); chk("c_rdata", dm_rsp_rdata, 32'h11111111); adv();
        settle(); chk("c_rsp_once", dm_rsp_valid, 0); adv();

        // Load that never gets a response
        dm_req_valid = 1; dm_req_addr = 32'h3000;
        settle(); chk("d_accept", dm_req_ready, 1); adv();
        dm_req_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            settle();
            chk("d_err", err, k == 9);
            if (k == 9) begin
                chk("d_rsp", dm_rsp_valid, 1);
                chk("d_rdata", dm_rsp_rdata, 0);
                chk("d_busy_last", busy, 1);
            end
            adv();
        end
        settle(); chk("d_idle", busy, 0); chk("d_err_clear", err, 0); adv();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h77777777;
        settle(); adv();
        mem_rsp_valid = 0;
        settle(); chk("d_stray_rsp", dm_rsp_valid, 0); chk("d_stray_data", dm_rsp_rdata, 0); adv();

        // Reset while waiting, then a late response
        if_req_valid = 1; if_req_addr = 32'h400;
        settle(); chk("e_accept", if_req_ready, 1); adv();
        if_req_valid = 0;
        cyc();
        rst = 1;
        settle(); chk("e_wait_busy", busy, 1); adv();
        rst = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
        settle();
        chk("e_rsp", if_rsp_valid, 0);
        chk("e_busy", busy, 0);
        chk("e_if_data", if_rsp_data, 0);
        chk("e_dm_data", dm_rsp_rdata, 0);
        chk("e_mem_valid", mem_req_valid, 0);
        adv();
        mem_rsp_valid = 0;
        settle(); chk("e_late_ignored", if_rsp_valid, 0); adv();
        auto_mem = 1; if_req_valid = 1; if_req_addr = 32'h500;
        settle(); chk("e_refetch_accept", if_req_ready, 1); adv();
        if_req_valid = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            settle();
            if (if_rsp_valid) begin
                got = 1;
                chk("e_refetch_data", if_rsp_data, 32'h5A5A0500);
            end
            adv();
        end
        chk("e_refetch_seen", got, 1);
        auto_mem = 0;
        mem_rsp_valid = 0;
        cyc();

        // Spurious response while idle
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFFFFFF;
        settle(); chk("f_no_rsp_now", if_rsp_valid, 0); adv();
        mem_rsp_valid = 0;
        settle();
        chk("f_if_rsp", if_rsp_valid, 0);
        chk("f_dm_rsp", dm_rsp_valid, 0);
        chk("f_if_data", if_rsp_data, 32'h5A5A0500);
        chk("f_dm_data", dm_rsp_rdata, 0);
        adv();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
